// File: rtl/rd_sched.sv
// Read-channel scheduler: arbitrates icache refills and data loads onto a single AXI
// read port, one transaction outstanding at a time, with starvation protection for
// instruction refills.
module rd_sched #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ILEN       = 1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic        inst_valid,
  output logic        inst_last,
  // data requester
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_ready,
  output logic        data_valid,
  // shared return path
  output logic [63:0] rd_rdata,
  output logic        rd_err,
  // AXI AR channel
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  // AXI R channel
  input  logic        rvalid,
  output logic        rready,
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam int unsigned CntW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  localparam logic [3:0] IdInst = 4'd0;
  localparam logic [3:0] IdData = 4'd1;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic [3:0]      id_q;
  logic [31:0]     addr_q;
  logic [7:0]      len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;

  logic inst_pri, grant_inst, grant_data;
  logic ar_hs, beat, id_match;

  // Arbitration: data wins unless the instruction side has waited STARVE_MAX grants
  always_comb begin
    inst_pri   = inst_req && (starve_q == StarveMax);
    grant_inst = (state_q == IDLE) && inst_req && (inst_pri || !data_req);
    grant_data = (state_q == IDLE) && data_req && !inst_pri;
  end

  // Next state and starvation counter
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: if (grant_inst || grant_data) state_d = ADDR;
      ADDR: if (arready) state_d = DATA;
      DATA: if (rvalid && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!inst_req || grant_inst) begin
      starve_d = '0;
    end else if (grant_data && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Latch the winner's AR fields at grant; held stable through ADDR and DATA
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (grant_inst) begin
      id_q    <= IdInst;
      addr_q  <= inst_addr;
      len_q   <= 8'(ILEN);
      size_q  <= 3'd3;
      burst_q <= 2'b01;
    end else if (grant_data) begin
      id_q    <= IdData;
      addr_q  <= data_addr;
      len_q   <= 8'd0;
      size_q  <= data_size;
      burst_q <= 2'b01;
    end
  end

  // AXI channel outputs and requester handshakes
  always_comb begin
    arvalid  = (state_q == ADDR);
    arid     = id_q;
    araddr   = addr_q;
    arlen    = len_q;
    arsize   = size_q;
    arburst  = burst_q;
    rready   = (state_q == DATA);

    ar_hs      = arvalid && arready;
    inst_ready = ar_hs && (id_q == IdInst);
    data_ready = ar_hs && (id_q == IdData);

    // Foreign-id beats are drained but never signalled to a requester
    beat       = (state_q == DATA) && rvalid;
    id_match   = (rid == id_q);
    inst_valid = beat && id_match && (id_q == IdInst);
    data_valid = beat && id_match && (id_q == IdData);
    inst_last  = inst_valid && rlast;
    rd_err     = beat && (rresp != 2'b00);
    rd_rdata   = beat ? rdata : 64'd0;
  end

endmodule

// File: tb/tb_rd_sched.sv
// Scoreboard bench for rd_sched: directed requests, a behavioural AXI slave, and a
// monitor that checks every AR and R handshake against queued expectations.
module tb_rd_sched;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic        last;
    logic        err;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ready, inst_valid, inst_last;
  logic        data_req = 1'b0;
  logic [31:0] data_addr = '0;
  logic [2:0]  data_size = '0;
  logic        data_ready, data_valid;
  logic [63:0] rd_rdata;
  logic        rd_err;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [3:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;

  rd_sched #(.STARVE_MAX(4), .ILEN(1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_last(inst_last),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_ready(data_ready), .data_valid(data_valid),
    .rd_rdata(rd_rdata), .rd_err(rd_err),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  ar_t         ar_exp[$];
  beat_t       beat_exp[$];
  logic [31:0] iq[$];
  logic [34:0] dq[$];

  logic inst_got = 1'b0;
  logic data_got = 1'b0;
  int   ar_delay = 0;
  logic [1:0] rresp_pat = 2'b00;
  int   last_ar_cycles = 0;

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic expect_inst(input logic [31:0] addr);
    beat_t b;
    ar_exp.push_back('{id: 4'd0, addr: addr, len: 8'd1, size: 3'd3, burst: 2'b01});
    for (int i = 0; i < 2; i++) begin
      b = '{iv: 1'b1, dv: 1'b0, last: (i == 1), err: 1'b0, data: {addr, 32'(i)}};
      beat_exp.push_back(b);
    end
  endtask

  task automatic expect_data(input logic [31:0] addr, input logic [2:0] size, input logic err);
    ar_exp.push_back('{id: 4'd1, addr: addr, len: 8'd0, size: size, burst: 2'b01});
    beat_exp.push_back('{iv: 1'b0, dv: 1'b1, last: 1'b0, err: err, data: {addr, 32'd0}});
  endtask

  task automatic check_zero(input string name);
    cmp(name, 128'({inst_ready, inst_valid, inst_last, data_ready, data_valid, rd_err, arvalid,
                   rready, arid, araddr, arlen, arsize, arburst, rd_rdata}), 128'd0);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (i < 400 && (ar_exp.size() != 0 || beat_exp.size() != 0 || iq.size() != 0 ||
                       dq.size() != 0)) begin
      @(posedge clk);
      i++;
    end
    if (i >= 400) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got %0d ar/%0d beats pending, want 0", name, ar_exp.size(),
               beat_exp.size());
      ar_exp.delete();
      beat_exp.delete();
      iq.delete();
      dq.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Requesters: hold each req until its ready pulse has been seen
  always @(posedge clk) begin
    #1;
    if (inst_got) begin
      if (iq.size() != 0) iq.delete(0);
      inst_got = 1'b0;
    end
    if (data_got) begin
      if (dq.size() != 0) dq.delete(0);
      data_got = 1'b0;
    end
    inst_req  = (iq.size() != 0);
    inst_addr = inst_req ? iq[0] : 32'd0;
    data_req  = (dq.size() != 0);
    data_addr = data_req ? dq[0][34:3] : 32'd0;
    data_size = data_req ? dq[0][2:0] : 3'd0;
  end

  // AXI slave: arready after ar_delay cycles, then arlen+1 beats of {addr, beat index}
  int s_ph = 0, s_wait = 0, s_beats = 0, s_beat = 0;
  logic [3:0]  s_id = '0;
  logic [31:0] s_addr = '0;

  task automatic drive_beat();
    rvalid = 1'b1;
    rid    = s_id;
    rdata  = {s_addr, 32'(s_beat)};
    rresp  = rresp_pat;
    rlast  = (s_beat == s_beats - 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      s_ph    = 0;
      s_wait  = 0;
    end else if (s_ph == 0) begin
      if (arready) begin
        arready = 1'b0;
        s_beats = int'(arlen) + 1;
        s_id    = arid;
        s_addr  = araddr;
        s_beat  = 0;
        s_ph    = 1;
        drive_beat();
      end else if (arvalid) begin
        if (s_wait >= ar_delay) arready = 1'b1;
        else s_wait++;
      end else begin
        s_wait = 0;
      end
    end else begin
      s_beat++;
      if (s_beat >= s_beats) begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        s_ph   = 0;
        s_wait = 0;
      end else begin
        drive_beat();
      end
    end
  end

  // Monitor: compare every handshake against the scoreboard, flag stray pulses
  logic        prev_wait = 1'b0;
  logic        prev_rlast = 1'b0;
  logic [31:0] prev_addr = '0;
  int          ar_cycles = 0;

  always @(negedge clk) begin
    ar_t   ea;
    beat_t eb;
    if (!reset) begin
      prev_wait  = 1'b0;
      prev_rlast = 1'b0;
      ar_cycles  = 0;
    end else begin
      if (prev_rlast) cmp("idle_gap_arvalid", 128'(arvalid), 128'd0);
      if (prev_wait && arvalid) cmp("araddr_stable", 128'(araddr), 128'(prev_addr));
      if (arvalid) ar_cycles++;
      if ((inst_ready || data_ready) && !(arvalid && arready))
        cmp("stray_ready", 128'({inst_ready, data_ready}), 128'd0);
      if ((inst_valid || data_valid) && !(rvalid && rready))
        cmp("stray_valid", 128'({inst_valid, data_valid}), 128'd0);
      if (arvalid && arready) begin
        last_ar_cycles = ar_cycles;
        ar_cycles = 0;
        if (ar_exp.size() == 0) begin
          cmp("unexpected_ar", 128'({arid, araddr}), 128'd0);
        end else begin
          ea = ar_exp.pop_front();
          cmp("ar_fields", 128'({arid, araddr, arlen, arsize, arburst}), 128'(ea));
          cmp("ar_ready", 128'({inst_ready, data_ready}),
              128'({ea.id == 4'd0, ea.id == 4'd1}));
        end
        if (inst_ready) inst_got = 1'b1;
        if (data_ready) data_got = 1'b1;
      end
      if (rvalid && rready) begin
        if (beat_exp.size() == 0) begin
          cmp("unexpected_beat", 128'({inst_valid, data_valid, rd_rdata}), 128'd0);
        end else begin
          eb = beat_exp.pop_front();
          cmp("r_beat", 128'({inst_valid, data_valid, inst_last, rd_err, rd_rdata}), 128'(eb));
        end
      end
      prev_wait  = arvalid && !arready;
      prev_addr  = araddr;
      prev_rlast = rvalid && rready && rlast;
    end
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    #2 reset = 1'b1;
    @(posedge clk);
    #2;

    // Single instruction refill
    expect_inst(32'h8000_0000);
    iq.push_back(32'h8000_0000);
    drain("inst_only");

    // Simultaneous requests: data first, instruction after a gap
    expect_data(32'h1000_0000, 3'd3, 1'b0);
    expect_inst(32'h8000_0008);
    dq.push_back({32'h1000_0000, 3'd3});
    iq.push_back(32'h8000_0008);
    drain("both_rise");

    // Starvation: four data grants, then the instruction, then the fifth data load
    for (int k = 0; k < 4; k++) expect_data(32'h1000_0100 + 32'(k * 8), 3'd2, 1'b0);
    expect_inst(32'h8000_0010);
    expect_data(32'h1000_0120, 3'd2, 1'b0);
    for (int k = 0; k < 5; k++) dq.push_back({32'h1000_0100 + 32'(k * 8), 3'd2});
    iq.push_back(32'h8000_0010);
    drain("starve");

    // Slow arready: AR held for 11 cycles
    ar_delay = 10;
    expect_inst(32'h8000_0040);
    iq.push_back(32'h8000_0040);
    drain("ar_stall");
    ar_delay = 0;
    cmp("ar_stall_cycles", 128'(last_ar_cycles), 128'd11);

    // Error response still delivered with valid
    rresp_pat = 2'b10;
    expect_data(32'h1000_0008, 3'd2, 1'b1);
    dq.push_back({32'h1000_0008, 3'd2});
    drain("rresp_err");
    rresp_pat = 2'b00;

    // Reset during beat 1 of 2
    ar_exp.push_back('{id: 4'd0, addr: 32'h8000_0080, len: 8'd1, size: 3'd3, burst: 2'b01});
    beat_exp.push_back('{iv: 1'b1, dv: 1'b0, last: 1'b0, err: 1'b0, data: {32'h8000_0080, 32'd0}});
    iq.push_back(32'h8000_0080);
    i = 0;
    @(negedge clk);
    while (i < 100 && !(rvalid && rready)) begin
      @(negedge clk);
      i++;
    end
    cmp("midburst_reached", 128'(rvalid && rready), 128'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_zero("midburst_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cmp("post_reset_ar_queue", 128'(ar_exp.size()), 128'd0);
    cmp("post_reset_beat_queue", 128'(beat_exp.size()), 128'd0);

    // Recovery after reset
    expect_data(32'h1000_0200, 3'd1, 1'b0);
    dq.push_back({32'h1000_0200, 3'd1});
    drain("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rd_sched.md
RD_SCHED -- requirements
Module: ysyx_22041752_rd_sched

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum number of consecutive data grants while an instruction request waits.
REQ-002 Parameter ILEN, default 1: arlen driven for instruction refill bursts (ILEN+1 beats).
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-005 inst_req  in  1  icache refill request; held high until inst_ready.
REQ-006 inst_addr  in  32  refill start address, 8-byte aligned.
REQ-007 inst_ready  out  1  one-cycle pulse: instruction AR accepted.
REQ-008 inst_valid  out  1  instruction read beat valid this cycle.
REQ-009 inst_last  out  1  qualifies inst_valid: final beat of the burst.
REQ-010 data_req  in  1  uncached/data load request; held high until data_ready.
REQ-011 data_addr  in  32  load address.
REQ-012 data_size  in  3  AXI size code for the load.
REQ-013 data_ready  out  1  one-cycle pulse: data AR accepted.
REQ-014 data_valid  out  1  data read beat valid this cycle.
REQ-015 rd_rdata  out  64  beat data, shared by both requesters.
REQ-016 rd_err  out  1  qualifies inst_valid/data_valid: rresp was non-zero.
REQ-017 arvalid/arready  out/in  1/1  AXI AR handshake.
REQ-018 arid  out  4  0 = instruction, 1 = data.
REQ-019 araddr  out  32  AR address.
REQ-020 arlen  out  8  ILEN for instruction, 0 for data.
REQ-021 arsize/arburst  out  3/2  3 and INCR (01) for instruction; data_size and INCR for data.
REQ-022 rvalid/rready  in/out  1/1  AXI R handshake.
REQ-023 rid/rdata/rresp/rlast  in  4/64/2/1  AXI R payload.

Function
REQ-024 FSM states: IDLE, ADDR, DATA; one transaction outstanding at a time.
REQ-025 IDLE: if any req is high, latch the winner's id, addr, len and size into registers, then go to ADDR the next cycle; otherwise stay in IDLE.
REQ-026 Arbitration, fixed priority: data wins over instruction, except when starve_cnt == STARVE_MAX and inst_req is high, in which case instruction wins.
REQ-027 starve_cnt, 3+ bits, saturating: incremented on a data grant while inst_req is high; cleared on an instruction grant or when inst_req is low.
REQ-028 ADDR: arvalid = 1 with the latched fields stable until arready; the cycle arvalid && arready pulses the winner's ready for one cycle and moves to DATA.
REQ-029 No ready pulse is produced without an AR handshake.
REQ-030 DATA: rready = 1; each rvalid cycle drives rd_rdata = rdata and asserts the latched owner's valid; rd_err = (rresp != 0).
REQ-031 Beats whose rid differs from the latched id are still accepted, but no valid is raised for them.
REQ-032 inst_last = rlast on instruction beats; the rlast beat returns the FSM to IDLE.
REQ-033 Back-to-back: arbitration in IDLE uses the req levels of the cycle after the rlast beat; minimum 1 idle cycle between transactions.
REQ-034 A req that drops before its ready pulse is ignored once latched: the transaction completes and its beats are still signalled.
REQ-035 Both reqs rising in the same cycle: REQ-026 applies; the loser stays pending with its req held.
REQ-036 rd_err does not abort a burst; the FSM waits for rlast.

Reset
REQ-037 While reset = 0: state = IDLE; starve_cnt = 0; arvalid, rready, all ready/valid/last/err outputs = 0; arid/araddr/arlen/arsize/arburst/rd_rdata = 0; reset taking effect mid-burst abandons the burst without emitting further valids.

Verification
REQ-038 inst_req only, addr 0x8000_0000, arready immediate, 2 beats -> arid 0, arlen 1, arsize 3; inst_ready pulse; inst_valid ×2, inst_last on 2nd.
REQ-039 inst_req and data_req rise in the same cycle -> data granted first (arid 1, arlen 0); instruction AR issued after the data rlast beat + 1 idle cycle.
REQ-040 inst_req held high with 5 back-to-back data_reqs, STARVE_MAX = 4 -> the 5th grant goes to instruction; starve_cnt = 0 afterwards.
REQ-041 arready held low 10 cycles -> arvalid and araddr stable for all 11 cycles; no ready pulse until the handshake.
REQ-042 Data beat with rresp = 2'b10 -> data_valid = 1 and rd_err = 1 in the same cycle; FSM returns to IDLE.
REQ-043 reset driven to 0 during DATA beat 1 of 2 -> all outputs 0 at once; after release, idle with no stray valids.
